// File: rtl/ldext_align_if.sv
// ldext_align_if: load-extend/align bus bundle.
//
// Handshake rule for both channels: a beat transfers on a rising clk edge
// where valid and ready are both 1. The producer holds valid and its payload
// stable until that beat transfers. ready may depend on the far side's ready.
//
//   in_valid / in_ready   : input channel (producer -> ldext_align)
//   in_data               : little-endian memory word
//   in_offset             : byte offset of the access within in_data
//   sx_op                 : extension op code
//   out_valid / out_ready : result channel (ldext_align -> consumer)
//   out_data              : aligned, extended result
//   out_split             : result was merged from two input beats
//
// Modports:
//   slave  : the ldext_align side
//   master : the testbench/producer+consumer side
interface ldext_align_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OFF_WIDTH  = $clog2(DATA_WIDTH / 8)
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [OFF_WIDTH-1:0]  in_offset;
  logic [2:0]            sx_op;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_split;

  modport slave (
    input  in_valid, in_data, in_offset, sx_op, out_ready,
    output in_ready, out_valid, out_data, out_split
  );

  modport master (
    output in_valid, in_data, in_offset, sx_op, out_ready,
    input  in_ready, out_valid, out_data, out_split
  );
endinterface

// File: rtl/ldext_align.sv
// ldext_align: aligns a load of 1/2/4 bytes out of a little-endian memory
// word and sign- or zero-extends it to DATA_WIDTH. An access that runs off
// the end of the word is completed by the next input beat (the following
// memory word) and the merged result is flagged with out_split.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   bus       : ldext_align_if slave modport (input and result channels)
//   dbg_state : current FSM state (0 IDLE, 1 WAIT_HI, 2 FULL)
//
// Op codes on sx_op:
//   0 SX_0700  1 SX_1500  2 SX_3100  3 SXU_0700  4 SXU_1500
//   5 SX_1100  6 SX_2000  7 unlisted (result zero)
module ldext_align #(
  parameter int DATA_WIDTH = 32,
  parameter int OFF_WIDTH  = $clog2(DATA_WIDTH / 8)
) (
  input  logic         clk,
  input  logic         rst,
  ldext_align_if.slave bus,
  output logic [1:0]   dbg_state
);

  localparam int NB = DATA_WIDTH / 8;

  localparam logic [2:0] SX_0700  = 3'd0;
  localparam logic [2:0] SX_1500  = 3'd1;
  localparam logic [2:0] SX_3100  = 3'd2;
  localparam logic [2:0] SXU_0700 = 3'd3;
  localparam logic [2:0] SXU_1500 = 3'd4;
  localparam logic [2:0] SX_1100  = 3'd5;
  localparam logic [2:0] SX_2000  = 3'd6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t state, state_next;

  // Access size in bytes; 0 marks ops that never span two words.
  function automatic logic [2:0] acc_size(input logic [2:0] op);
    case (op)
      SX_0700, SXU_0700: acc_size = 3'd1;
      SX_1500, SXU_1500: acc_size = 3'd2;
      SX_3100:           acc_size = 3'd4;
      default:           acc_size = 3'd0;
    endcase
  endfunction

  // v holds the access already shifted down to bit 0; raw is the unshifted
  // word, used by the fixed-field ops that ignore the offset.
  function automatic logic [DATA_WIDTH-1:0] extend(
    input logic [DATA_WIDTH-1:0] v,
    input logic [DATA_WIDTH-1:0] raw,
    input logic [2:0]            op
  );
    case (op)
      SX_0700:  extend = DATA_WIDTH'($signed(v[7:0]));
      SX_1500:  extend = DATA_WIDTH'($signed(v[15:0]));
      SX_3100:  extend = DATA_WIDTH'($signed(v[31:0]));
      SXU_0700: extend = DATA_WIDTH'(v[7:0]);
      SXU_1500: extend = DATA_WIDTH'(v[15:0]);
      SX_1100:  extend = DATA_WIDTH'($signed(raw[11:0]));
      SX_2000:  extend = DATA_WIDTH'($signed(raw[20:0]));
      default:  extend = '0;
    endcase
  endfunction

  // Captured first-beat context for a split access.
  logic [DATA_WIDTH-1:0] lo_q;
  logic [2:0]            op_q;
  logic [OFF_WIDTH-1:0]  off_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_split_q;

  logic                  in_ready_c;
  logic                  in_hs;
  logic [2:0]            sz;
  logic [OFF_WIDTH:0]    end_pos;
  logic                  is_split;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] single_res;
  logic [OFF_WIDTH+3:0]  hi_shift;
  logic [DATA_WIDTH-1:0] merged_raw;
  logic [DATA_WIDTH-1:0] merged_res;

  assign in_ready_c = (state != FULL) || bus.out_ready;
  assign in_hs      = bus.in_valid && in_ready_c;

  assign sz       = acc_size(bus.sx_op);
  assign end_pos  = {1'b0, bus.in_offset} + (OFF_WIDTH + 1)'(sz);
  assign is_split = (sz != 3'd0) && (end_pos > (OFF_WIDTH + 1)'(NB));

  // Low bytes of the access moved down to byte 0.
  assign shifted    = bus.in_data >> {bus.in_offset, 3'b000};
  assign single_res = extend(shifted, bus.in_data, bus.sx_op);

  // The first beat contributed NB-off_q bytes; the second beat's byte 0
  // lands directly above them.
  assign hi_shift   = {((OFF_WIDTH + 1)'(NB) - {1'b0, off_q}), 3'b000};
  assign merged_raw = lo_q | (bus.in_data << hi_shift);
  assign merged_res = extend(merged_raw, merged_raw, op_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic. From FULL, a new input beat is only accepted together
  // with the output handshake, so that path reuses the IDLE decision.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_hs) state_next = is_split ? WAIT_HI : FULL;
      end
      WAIT_HI: begin
        if (in_hs) state_next = FULL;
      end
      FULL: begin
        if (bus.out_ready) begin
          if (bus.in_valid) state_next = is_split ? WAIT_HI : FULL;
          else              state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.in_ready  = in_ready_c;
    bus.out_valid = (state == FULL);
    bus.out_data  = out_data_q;
    bus.out_split = out_split_q;
    dbg_state     = state;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_split_q <= 1'b0;
      lo_q        <= '0;
      op_q        <= '0;
      off_q       <= '0;
    end else if (in_hs) begin
      if (state == WAIT_HI) begin
        // Second beat: its offset and op are ignored.
        out_data_q  <= merged_res;
        out_split_q <= 1'b1;
        lo_q        <= '0;
      end else if (is_split) begin
        lo_q  <= shifted;
        op_q  <= bus.sx_op;
        off_q <= bus.in_offset;
      end else begin
        out_data_q  <= single_res;
        out_split_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ldext_align.sv
module tb_ldext_align;

  localparam logic [2:0] SX_0700  = 3'd0;
  localparam logic [2:0] SX_1500  = 3'd1;
  localparam logic [2:0] SX_3100  = 3'd2;
  localparam logic [2:0] SXU_0700 = 3'd3;
  localparam logic [2:0] SXU_1500 = 3'd4;
  localparam logic [2:0] SX_1100  = 3'd5;
  localparam logic [2:0] SX_2000  = 3'd6;
  localparam logic [2:0] SX_BAD   = 3'd7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ldext_align_if #(.DATA_WIDTH(32)) bus32 ();
  ldext_align_if #(.DATA_WIDTH(64)) bus64 ();
  logic [1:0] st32;
  logic [1:0] st64;

  ldext_align #(.DATA_WIDTH(32)) dut32 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus32.slave),
    .dbg_state (st32)
  );

  ldext_align #(.DATA_WIDTH(64)) dut64 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus64.slave),
    .dbg_state (st64)
  );

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];  // {out_split, out_data}
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic split, input logic [31:0] data);
    exp_q.push_back({split, data});
  endtask

  // Called just before an edge: if the result channel handshakes on that
  // edge, the result is compared with the oldest expectation.
  task automatic sb_pop();
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL sb_empty_pop: got %h expected none", {bus32.out_split, bus32.out_data});
    end else begin
      e = exp_q.pop_front();
      chk("sb_result", {31'b0, bus32.out_split, bus32.out_data}, {31'b0, e});
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; one call advances one full cycle.
  task automatic cyc();
    #1;
    if (bus32.out_valid && bus32.out_ready) sb_pop();
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] d, input logic [1:0] off, input logic [2:0] op);
    bus32.in_valid  = 1'b1;
    bus32.in_data   = d;
    bus32.in_offset = off;
    bus32.sx_op     = op;
  endtask

  task automatic send(input logic [31:0] d, input logic [1:0] off, input logic [2:0] op);
    drive(d, off, op);
    cyc();
    bus32.in_valid = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", bus32.out_valid, 1'b0);
    chk("rst_out_data", bus32.out_data, 32'h0);
    chk("rst_out_split", bus32.out_split, 1'b0);
    chk("rst_in_ready", bus32.in_ready, 1'b1);
    chk("rst_state", st32, 2'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic [1:0]  off;
    logic [7:0]  b;
    logic [31:0] e;

    bus32.in_valid = 1'b0; bus32.in_data = '0; bus32.in_offset = '0;
    bus32.sx_op = '0; bus32.out_ready = 1'b1;
    bus64.in_valid = 1'b0; bus64.in_data = '0; bus64.in_offset = '0;
    bus64.sx_op = '0; bus64.out_ready = 1'b1;

    @(negedge clk);
    chk("reset_in_ready", bus32.in_ready, 1'b1);
    chk("reset_out_valid", bus32.out_valid, 1'b0);
    chk("reset_out_data", bus32.out_data, 32'h0);
    chk("reset_state", st32, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("post_reset_in_ready", bus32.in_ready, 1'b1);

    // SX_0700 at offset 3, result one cycle after the input handshake
    push(1'b0, 32'hFFFF_FF80);
    send(32'h8012_3456, 2'd3, SX_0700);
    chk("lat_out_valid", bus32.out_valid, 1'b1);
    chk("lat_out_data", bus32.out_data, 32'hFFFF_FF80);
    cyc();
    chk("idle_after_pop", bus32.out_valid, 1'b0);

    // SXU_1500 at offset 1
    push(1'b0, 32'h0000_ABCD);
    send(32'h12AB_CD34, 2'd1, SXU_1500);
    cyc();

    // SX_3100 at offset 2, split over two beats; second beat op/offset junk
    push(1'b1, 32'hDEF0_1234);
    send(32'h1234_5678, 2'd2, SX_3100);
    chk("split_gap_valid", bus32.out_valid, 1'b0);
    chk("split_gap_state", st32, 2'd1);
    send(32'h9ABC_DEF0, 2'd3, SX_BAD);
    chk("split_out_valid", bus32.out_valid, 1'b1);
    cyc();

    // Zero- and sign-extended halfword splits at offset 3
    push(1'b1, 32'h0000_9180);
    send(32'h8000_0000, 2'd3, SXU_1500);
    send(32'h0000_0091, 2'd0, SX_0700);
    cyc();
    push(1'b1, 32'hFFFF_F2C5);
    send(32'hC500_0000, 2'd3, SX_1500);
    send(32'h0000_00F2, 2'd1, SXU_0700);
    cyc();

    // Fixed-field ops ignore offset; unlisted op yields zero
    push(1'b0, 32'hFFFF_F800);
    send(32'h0000_0800, 2'd3, SX_1100);
    cyc();
    push(1'b0, 32'h0000_07FF);
    send(32'hFFFF_F7FF, 2'd2, SX_1100);
    cyc();
    push(1'b0, 32'h0000_0000);
    send(32'hFFFF_FFFF, 2'd3, SX_BAD);
    cyc();

    // Back-pressure: result held three cycles, then back-to-back results
    bus32.out_ready = 1'b0;
    push(1'b0, 32'h0000_0056);
    send(32'h0000_0056, 2'd0, SXU_0700);
    push(1'b0, 32'hFFFF_8001);
    drive(32'h0000_8001, 2'd0, SX_1500);
    for (int i = 0; i < 3; i++) begin
      chk("stall_out_data", bus32.out_data, 32'h0000_0056);
      chk("stall_in_ready", bus32.in_ready, 1'b0);
      cyc();
    end
    bus32.out_ready = 1'b1;
    cyc();
    push(1'b0, 32'hFFF0_0000);
    drive(32'h0010_0000, 2'd1, SX_2000);
    chk("b2b_valid_1", bus32.out_valid, 1'b1);
    cyc();
    bus32.in_valid = 1'b0;
    chk("b2b_valid_2", bus32.out_valid, 1'b1);
    cyc();
    chk("b2b_drained", bus32.out_valid, 1'b0);

    // Reset in WAIT_HI, then a fresh first beat
    send(32'hAB00_0000, 2'd3, SX_1500);
    chk("pre_rst_wait_hi", st32, 2'd1);
    pulse_rst();
    push(1'b0, 32'h0000_007F);
    send(32'h0000_007F, 2'd0, SX_0700);
    cyc();

    // Reset in FULL
    bus32.out_ready = 1'b0;
    send(32'h0000_0011, 2'd0, SXU_0700);
    chk("pre_rst_full", bus32.out_valid, 1'b1);
    pulse_rst();
    bus32.out_ready = 1'b1;

    // Random single-byte loads
    for (int i = 0; i < 8; i++) begin
      d   = $urandom;
      off = 2'($urandom_range(0, 3));
      b   = 8'((d >> (8 * off)) & 32'hFF);
      if ((i % 2) == 0) e = b[7] ? {24'hFFFFFF, b} : {24'h0, b};
      else              e = {24'h0, b};
      push(1'b0, e);
      send(d, off, ((i % 2) == 0) ? SX_0700 : SXU_0700);
      cyc();
    end

    // 64-bit instance: SX_3100 at offset 4
    bus64.in_valid = 1'b1; bus64.in_data = 64'h8000_0000_0000_0000;
    bus64.in_offset = 3'd4; bus64.sx_op = SX_3100;
    @(negedge clk);
    bus64.in_valid = 1'b0;
    chk("w64_valid", bus64.out_valid, 1'b1);
    chk("w64_data", bus64.out_data, 64'hFFFF_FFFF_8000_0000);
    chk("w64_split", bus64.out_split, 1'b0);
    @(negedge clk);
    // 64-bit split: SX_3100 at offset 6
    bus64.in_valid = 1'b1; bus64.in_data = 64'h1234_0000_0000_0000;
    bus64.in_offset = 3'd6; bus64.sx_op = SX_3100;
    @(negedge clk);
    chk("w64_gap_valid", bus64.out_valid, 1'b0);
    bus64.in_data = 64'h0000_0000_0000_5678; bus64.in_offset = 3'd0;
    @(negedge clk);
    bus64.in_valid = 1'b0;
    chk("w64_split_data", bus64.out_data, 64'h0000_0000_5678_1234);
    chk("w64_split_flag", bus64.out_split, 1'b1);
    @(negedge clk);

    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ldext_align.md
LDEXT_ALIGN -- requirements
Module: ldext_align

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the memory word and result width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter OFF_WIDTH, default $clog2(DATA_WIDTH/8), giving the byte-offset width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data, in_offset and sx_op are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the current input beat.
REQ-007 The block SHALL have port in_data, input, DATA_WIDTH bits: little-endian memory word.
REQ-008 The block SHALL have port in_offset, input, OFF_WIDTH bits: byte offset of the access within in_data.
REQ-009 The block SHALL have port sx_op, input, 3 bits: isa_shared extension op (SX_0700, SX_1500, SX_3100, SXU_0700, SXU_1500, SX_1100, SX_2000).
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data holds a result.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port out_data, output, DATA_WIDTH bits: the aligned, extended result.
REQ-013 The block SHALL have port out_split, output, 1 bit: the result was merged from two beats.

Function
REQ-014 An input handshake SHALL occur when in_valid and in_ready are both 1 on a rising edge; an output handshake SHALL occur when out_valid and out_ready are both 1.
REQ-015 Access size SHALL be 1 byte for SX_0700/SXU_0700, 2 bytes for SX_1500/SXU_1500, and 4 bytes for SX_3100.
REQ-016 Load ops SHALL take bytes starting at in_offset.
REQ-017 SX_* load ops SHALL sign-extend from the top bit of the access to DATA_WIDTH; SXU_* ops SHALL zero-extend.
REQ-018 SX_1100 and SX_2000 SHALL ignore in_offset, SHALL sign-extend in_data[11:0] and in_data[20:0] respectively, and SHALL always be single-beat.
REQ-019 The block SHALL have states IDLE, WAIT_HI and FULL.
REQ-020 In IDLE, an input handshake where in_offset plus size is at most DATA_WIDTH/8 SHALL load the output register with the result and go to FULL.
REQ-021 In IDLE, an input handshake where in_offset plus size exceeds DATA_WIDTH/8 SHALL capture the low bytes, sx_op and offset, and go to WAIT_HI.
REQ-022 In WAIT_HI, the next input handshake SHALL be the following memory word; its in_offset and sx_op SHALL be ignored.
REQ-023 In WAIT_HI, the upper bytes SHALL be taken from byte 0 upward of the second beat, and the merged result SHALL be loaded with out_split=1, going to FULL.
REQ-024 Latency SHALL be one cycle: out_valid rises on the edge of the final input handshake.
REQ-025 in_ready SHALL equal (state != FULL) OR out_ready.
REQ-026 In FULL, an output handshake together with a new input handshake SHALL proceed per REQ-020/021 with no bubble; an output handshake alone SHALL return to IDLE.
REQ-027 In FULL, out_data and out_split SHALL hold stable while out_ready=0.
REQ-028 out_valid SHALL be 1 only in FULL.
REQ-029 An unlisted sx_op SHALL produce zero with out_split=0, single-beat.

Reset
REQ-030 rst SHALL immediately force state to IDLE, out_valid=0, out_data=0, out_split=0, and clear the captured low bytes, including when asserted mid-WAIT_HI or in FULL.
REQ-031 After rst deasserts, the first accepted beat SHALL be treated as a first beat.
REQ-032 in_ready SHALL be 1 during and after reset.

Verification (DATA_WIDTH=32 unless stated)
REQ-033 The bench SHALL cover: SX_0700, offset 3, in_data 0x80123456 -> out_data 0xFFFFFF80, out_split=0, one cycle later.
REQ-034 The bench SHALL cover: SXU_1500, offset 1, in_data 0x12ABCD34 -> out_data 0x0000ABCD.
REQ-035 The bench SHALL cover: SX_3100, offset 2, beats 0x12345678 then 0x9ABCDEF0 -> out_data 0xDEF01234, out_split=1, out_valid=0 between the beats.
REQ-036 The bench SHALL cover: a result present with out_ready=0 for 3 cycles -> out_data stable, in_ready=0; out_ready=1 with in_valid=1 -> back-to-back results.
REQ-037 The bench SHALL cover: rst pulse in WAIT_HI -> out_valid=0; next SX_0700 beat 0x0000007F at offset 0 -> 0x0000007F, out_split=0.
REQ-038 The bench SHALL cover: SX_1100 with in_data 0x00000800 -> 0xFFFFF800, and, with DATA_WIDTH=64, SX_3100 at offset 4 with in_data 0x80000000_00000000 -> 0xFFFFFFFF80000000.
